// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-cycle WIDTH-bit add/subtract engine built around one 4-bit ripple
// slice, stepped LS nibble first with the carry registered between nibbles.

module nsa_slice4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  logic c;

  always_comb begin
    c   = c_i;
    s_o = '0;
    for (int k = 0; k < 4; k++) begin
      s_o[k] = a_i[k] ^ b_i[k] ^ c;
      c      = (a_i[k] & b_i[k]) | (c & (a_i[k] ^ b_i[k]));
    end
    c_o = c;
  end
endmodule

module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy
);
  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
    $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 8");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] a_q, beff_q, res_q;
  logic             carry_q, co_q, ov_q;

  logic [IW+1:0]    base;
  logic [3:0]       slice_s;
  logic             slice_c;

  assign base = {idx_q, 2'b00};

  nsa_slice4 u_slice (
    .a_i (a_q[base +: 4]),
    .b_i (beff_q[base +: 4]),
    .c_i (carry_q),
    .s_o (slice_s),
    .c_o (slice_c)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      beff_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          // Subtract as A + ~B + 1: the +1 rides in on the preloaded carry.
          a_q     <= a;
          beff_q  <= sub ? ~b : b;
          carry_q <= sub;
          idx_q   <= '0;
          state_q <= RUN;
        end
        RUN: begin
          res_q[base +: 4] <= slice_s;
          carry_q          <= slice_c;
          idx_q            <= idx_q + 1'b1;
          if (idx_q == IW'(N - 1)) begin
            co_q    <= slice_c;
            ov_q    <= (a_q[WIDTH-1] == beff_q[WIDTH-1]) && (slice_s[3] != a_q[WIDTH-1]);
            state_q <= DONE;
          end
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = res_q;
  assign carry_out = co_q;
  assign overflow  = ov_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Scoreboard bench for nibble_serial_adder_ctrl: a 16-bit and an 8-bit instance.

module tb_nibble_serial_adder_ctrl;
  typedef struct { logic [15:0] r; logic co; logic ov; } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, sub, out_ready;
  logic [15:0] a, b;
  logic        in_ready, out_valid, carry_out, overflow, busy;
  logic [15:0] result;

  logic        in_valid8, sub8, out_ready8;
  logic [7:0]  a8, b8, result8;
  logic        in_ready8, out_valid8, carry_out8, overflow8, busy8;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry_out(carry_out), .overflow(overflow), .busy(busy)
  );

  nibble_serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .sub(sub8), .out_valid(out_valid8), .out_ready(out_ready8),
    .result(result8), .carry_out(carry_out8), .overflow(overflow8), .busy(busy8)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Reference: signed/unsigned integer arithmetic, independent of the nibble datapath.
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic s);
    exp_t e;
    int   sx, sy, sr;
    sx = int'($signed(x));
    sy = int'($signed(y));
    sr = s ? sx - sy : sx + sy;
    e.r  = s ? x - y : x + y;
    e.co = s ? (x >= y) : ((32'(x) + 32'(y)) > 32'd65535);
    e.ov = (sr > 32767) || (sr < -32768);
    return e;
  endfunction

  // Push the expectation, wait for in_ready, then hold in_valid across one edge.
  task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic s, input exp_t e);
    int n = 0;
    sb.push_back(e);
    a = x; b = y; sub = s; in_valid = 1'b1;
    while (!in_ready && n < 50) begin tick(); n++; end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b1; a = 16'h1111; b = 16'h2222; sub = 1'b0; out_ready = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0; out_ready8 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || result !== 16'h0 || carry_out !== 1'b0 || overflow !== 1'b0) begin
        errors++;
        $display("FAIL reset: ov=%b busy=%b res=%h co=%b ovf=%b, required 0/0/0000/0/0",
                 out_valid, busy, result, carry_out, overflow);
      end
    end
    reset_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_release: in_ready=%b busy=%b, required 1/0", in_ready, busy);
    end
  endtask

  task automatic run_op(input string nm, input logic [15:0] x, input logic [15:0] y, input logic s, input exp_t e);
    int   lat;
    exp_t q;
    issue(x, y, s, e);
    wait_out(lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL %s_latency: got %0d, required 4", nm, lat); end
    q = sb.pop_front();
    checks++;
    if (result !== q.r || carry_out !== q.co || overflow !== q.ov) begin
      errors++;
      $display("FAIL %s: res=%h co=%b ovf=%b, required %h/%b/%b", nm, result, carry_out, overflow, q.r, q.co, q.ov);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL %s_handshake: out_valid=%b in_ready=%b, required 0/1", nm, out_valid, in_ready);
    end
  endtask

  task automatic test_add();
    run_op("add_basic", 16'h1234, 16'h0FFF, 1'b0, '{16'h2233, 1'b0, 1'b0});
  endtask

  task automatic test_carry_ovf();
    run_op("add_carry", 16'hFFFF, 16'h0001, 1'b0, '{16'h0000, 1'b1, 1'b0});
    run_op("add_ovf",   16'h7FFF, 16'h0001, 1'b0, '{16'h8000, 1'b0, 1'b1});
  endtask

  task automatic test_sub();
    run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, '{16'hFFFE, 1'b0, 1'b0});
    run_op("sub_ovf",    16'h8000, 16'h0001, 1'b1, '{16'h7FFF, 1'b1, 1'b1});
  endtask

  task automatic test_random();
    logic [15:0] x, y;
    logic        s;
    for (int i = 0; i < 8; i++) begin
      x = 16'($urandom); y = 16'($urandom); s = 1'($urandom_range(1));
      run_op("random", x, y, s, model(x, y, s));
    end
  endtask

  task automatic test_back_to_back();
    int   lat;
    exp_t q;
    issue(16'h1111, 16'h2222, 1'b0, '{16'h3333, 1'b0, 1'b0});
    wait_out(lat);
    // New op offered while the result is stalled by the consumer.
    a = 16'h0100; b = 16'h0200; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    sb.push_back(model(16'h0100, 16'h0200, 1'b0));
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 16'h3333) begin
        errors++;
        $display("FAIL backpressure: out_valid=%b in_ready=%b res=%h, required 1/0/3333", out_valid, in_ready, result);
      end
    end
    q = sb.pop_front();
    checks++;
    if (result !== q.r || carry_out !== q.co || overflow !== q.ov) begin
      errors++; $display("FAIL bp_result: res=%h, required %h", result, q.r);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL simul_done_idle: out_valid=%b in_ready=%b busy=%b, required 0/1/0", out_valid, in_ready, busy);
    end
    tick(); in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL simul_accept: busy=%b in_ready=%b, required 1/0", busy, in_ready);
    end
    wait_out(lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL simul_latency: got %0d, required 4", lat); end
    q = sb.pop_front();
    checks++;
    if (result !== q.r || carry_out !== q.co || overflow !== q.ov) begin
      errors++; $display("FAIL simul_result: res=%h co=%b ovf=%b, required %h/%b/%b", result, carry_out, overflow, q.r, q.co, q.ov);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_reset_abort();
    bit seen = 1'b0;
    a = 16'hABCD; b = 16'h1234; sub = 1'b0; in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 16'h0) begin
      errors++;
      $display("FAIL reset_abort: busy=%b out_valid=%b in_ready=%b res=%h, required 0/0/1/0000", busy, out_valid, in_ready, result);
    end
    for (int i = 0; i < 8; i++) begin tick(); if (out_valid) seen = 1'b1; end
    checks++;
    if (seen) begin errors++; $display("FAIL reset_abort_pulse: out_valid seen=1, required 0"); end
  endtask

  task automatic test_width8();
    int lat = 0;
    a8 = 8'h80; b8 = 8'h80; sub8 = 1'b0; in_valid8 = 1'b1;
    tick(); in_valid8 = 1'b0;
    while (!out_valid8 && lat < 50) begin tick(); lat++; end
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL w8_latency: got %0d, required 2", lat); end
    checks++;
    if (result8 !== 8'h00 || carry_out8 !== 1'b1 || overflow8 !== 1'b1) begin
      errors++; $display("FAIL w8_result: res=%h co=%b ovf=%b, required 00/1/1", result8, carry_out8, overflow8);
    end
    out_ready8 = 1'b1; tick(); out_ready8 = 1'b0;
    checks++;
    if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
      errors++; $display("FAIL w8_handshake: out_valid=%b in_ready=%b, required 0/1", out_valid8, in_ready8);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_carry_ovf();
    test_sub();
    test_random();
    test_back_to_back();
    test_reset_abort();
    test_width8();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d left, required 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
